// File: rtl/coolgirl_pkg.sv
// Shared definitions for the mapper IRQ blocks.
//   - irq_sel_e : register-select codes for the $C000-$E001 window,
//                 encoded as {cpu_addr_in[13], cpu_addr_in[0]}
//   - LOW_MIN_DEFAULT : default minimum A12 low time, in m2 cycles
package coolgirl_pkg;

  typedef enum logic [1:0] {
    IRQ_LATCH   = 2'b00,  // $C000: reload value
    IRQ_RELOAD  = 2'b01,  // $C001: force reload on next edge
    IRQ_DISABLE = 2'b10,  // $E000: disable and acknowledge
    IRQ_ENABLE  = 2'b11   // $E001: enable
  } irq_sel_e;

  localparam int LOW_MIN_DEFAULT = 3;

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// CPU register-write bus into the scanline IRQ unit.
//   reg_we   : one-cycle write strobe for this mapper's $C000-$FFFF window
//   reg_sel  : {cpu_addr_in[13], cpu_addr_in[0]}
//   reg_data : CPU data bus value
// master = mapper register decode, slave = IRQ unit.
interface mmc3_scanline_irq_if #(
  parameter int CNT_W = 8
);
  logic             reg_we;
  logic [1:0]       reg_sel;
  logic [CNT_W-1:0] reg_data;

  modport master (output reg_we, output reg_sel, output reg_data);
  modport slave  (input  reg_we, input  reg_sel, input  reg_data);
endinterface

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// PPU A12 rising-edge qualifier.
// Synchronises the raw A12 line into the m2 domain and emits a one-cycle
// pulse on a rising edge that was preceded by at least LOW_MIN consecutive
// low samples. Short low glitches (sprite/BG fetch interleave) are ignored.
//   m2       : clock
//   reset_n  : synchronous active-low reset
//   ppu_a12  : raw PPU address bit 12 (asynchronous)
//   edge_out : qualified rising edge, valid for the cycle ending at the
//              posedge where the parent acts on it
module a12_edge_filter #(
  parameter int LOW_MIN = 3
) (
  input  logic m2,
  input  logic reset_n,
  input  logic ppu_a12,
  output logic edge_out
);

  localparam logic [3:0] LOW_MAX = 4'(LOW_MIN);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [3:0] low_cnt;

  // Synchroniser, previous-sample register and saturating low-time counter.
  always_ff @(posedge m2) begin
    if (!reset_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      low_cnt <= 4'd0;
    end else begin
      s1 <= ppu_a12;
      s2 <= s1;
      s3 <= s2;
      if (s2) begin
        low_cnt <= 4'd0;
      end else if (low_cnt != LOW_MAX) begin
        low_cnt <= low_cnt + 4'd1;
      end else begin
        low_cnt <= low_cnt;
      end
    end
  end

  // Decoded straight from flops so the parent steps at posedge k+2 after a
  // raw rise before posedge k; registering it would add a cycle of latency.
  assign edge_out = s2 & ~s3 & (low_cnt == LOW_MAX);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ unit.
// Counts qualified PPU A12 rising edges with a reloadable down-counter and
// raises irq_out when the counter lands on zero while enabled.
//   m2          : CPU M2, sole clock
//   reset_n     : synchronous active-low reset
//   ppu_a12     : raw PPU A12
//   bus         : register-write bus (slave modport)
//   irq_out     : active-high IRQ request, held until $E000
//   counter_dbg : current counter value
// REV_A selects the rev A rule (IRQ only on a transition into zero) versus
// rev B (IRQ on every edge that leaves the counter at zero).
module mmc3_scanline_irq
  import coolgirl_pkg::*;
#(
  parameter int LOW_MIN = LOW_MIN_DEFAULT,
  parameter bit REV_A   = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic                 m2,
  input  logic                 reset_n,
  input  logic                 ppu_a12,
  mmc3_scanline_irq_if.slave   bus,
  output logic                 irq_out,
  output logic [CNT_W-1:0]     counter_dbg
);

  logic [CNT_W-1:0] latch;
  logic [CNT_W-1:0] counter;
  logic             reload_pend;
  logic             enabled;
  logic             qual_edge;
  logic             step_reload;
  logic [CNT_W-1:0] next_count;
  logic             irq_set;

  a12_edge_filter #(.LOW_MIN(LOW_MIN)) u_edge_filter (
    .m2       (m2),
    .reset_n  (reset_n),
    .ppu_a12  (ppu_a12),
    .edge_out (qual_edge)
  );

  // Counter value and IRQ condition that a qualified edge would produce.
  always_comb begin
    step_reload = (counter == {CNT_W{1'b0}}) || reload_pend;
    if (step_reload) begin
      next_count = latch;
    end else begin
      next_count = counter - {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (REV_A) begin
      // Reloading zero onto zero with no pending reload is not a transition.
      irq_set = enabled && (next_count == {CNT_W{1'b0}}) &&
                ((counter != {CNT_W{1'b0}}) || reload_pend);
    end else begin
      irq_set = enabled && (next_count == {CNT_W{1'b0}});
    end
  end

  // Register writes take priority; an edge in the same cycle is dropped.
  always_ff @(posedge m2) begin
    if (!reset_n) begin
      latch       <= {CNT_W{1'b0}};
      counter     <= {CNT_W{1'b0}};
      reload_pend <= 1'b0;
      enabled     <= 1'b0;
      irq_out     <= 1'b0;
    end else if (bus.reg_we) begin
      case (irq_sel_e'(bus.reg_sel))
        IRQ_LATCH: begin
          latch <= bus.reg_data;
        end
        IRQ_RELOAD: begin
          counter     <= {CNT_W{1'b0}};
          reload_pend <= 1'b1;
        end
        IRQ_DISABLE: begin
          enabled <= 1'b0;
          irq_out <= 1'b0;
        end
        IRQ_ENABLE: begin
          enabled <= 1'b1;
        end
        default: begin
          enabled <= enabled;
        end
      endcase
    end else if (qual_edge) begin
      counter     <= next_count;
      reload_pend <= 1'b0;
      if (irq_set) begin
        irq_out <= 1'b1;
      end else begin
        irq_out <= irq_out;
      end
    end else begin
      counter <= counter;
    end
  end

  assign counter_dbg = counter;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Directed bench for mmc3_scanline_irq. Two instances (rev B and rev A)
// share stimulus; a window-based model predicts qualified edges from the
// raw A12 sample history and the counter/IRQ rules are applied on top.
module tb_mmc3_scanline_irq;
  import coolgirl_pkg::*;

  localparam int CNT_W   = 8;
  localparam int LOW_MIN = 3;

  logic             m2 = 1'b0;
  logic             reset_n = 1'b0;
  logic             ppu_a12 = 1'b0;
  logic             irq_b;
  logic             irq_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_a;

  mmc3_scanline_irq_if #(.CNT_W(CNT_W)) bus_if ();

  mmc3_scanline_irq #(.LOW_MIN(LOW_MIN), .REV_A(1'b0), .CNT_W(CNT_W)) u_rev_b (
    .m2(m2), .reset_n(reset_n), .ppu_a12(ppu_a12), .bus(bus_if),
    .irq_out(irq_b), .counter_dbg(cnt_b)
  );

  mmc3_scanline_irq #(.LOW_MIN(LOW_MIN), .REV_A(1'b1), .CNT_W(CNT_W)) u_rev_a (
    .m2(m2), .reset_n(reset_n), .ppu_a12(ppu_a12), .bus(bus_if),
    .irq_out(irq_a), .counter_dbg(cnt_a)
  );

  always #5 m2 = ~m2;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit             hist [0:8191];   // raw A12 value seen at each posedge
  int             cyc = 0;
  int             rst_cyc = -100;
  bit             valid = 1'b0;
  logic [CNT_W-1:0] m_latch, m_cnt;
  bit             m_pend, m_en, m_irq_b, m_irq_a;

  // Synchronised A12 at the end of posedge j is the raw sample from j-1,
  // forced low for the two posedges following a reset. An edge at posedge k
  // needs a high synchronised sample at k-1 and LOW_MIN low ones before it,
  // all taken no earlier than the last reset.
  function automatic bit model_edge(input int k);
    int j;
    if (k - 2 <= rst_cyc) return 1'b0;
    if (!hist[k-2]) return 1'b0;
    for (int i = 1; i <= LOW_MIN; i++) begin
      j = k - 1 - i;
      if (j < rst_cyc) return 1'b0;
      if ((j - 1 > rst_cyc) && hist[j-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge m2) begin : model_proc
    bit             e;
    logic [CNT_W-1:0] old;
    bit             was_pend;
    cyc++;
    hist[cyc] = ppu_a12;
    if (!reset_n) begin
      m_latch = '0; m_cnt = '0; m_pend = 1'b0; m_en = 1'b0;
      m_irq_b = 1'b0; m_irq_a = 1'b0;
      rst_cyc = cyc;
      valid = 1'b1;
    end else if (valid) begin
      e = model_edge(cyc);
      if (bus_if.reg_we) begin
        case (bus_if.reg_sel)
          IRQ_LATCH:   m_latch = bus_if.reg_data;
          IRQ_RELOAD:  begin m_cnt = '0; m_pend = 1'b1; end
          IRQ_DISABLE: begin m_en = 1'b0; m_irq_b = 1'b0; m_irq_a = 1'b0; end
          default:     m_en = 1'b1;
        endcase
      end else if (e) begin
        old = m_cnt;
        was_pend = m_pend;
        m_cnt = (old == 0 || was_pend) ? m_latch : old - 1;
        m_pend = 1'b0;
        if (m_en && m_cnt == 0) m_irq_b = 1'b1;
        if (m_en && m_cnt == 0 && (old != 0 || was_pend)) m_irq_a = 1'b1;
      end
    end
    #1;
    if (valid) begin
      check("cyc_counter_b", cnt_b, m_cnt);
      check("cyc_counter_a", cnt_a, m_cnt);
      check("cyc_irq_b", irq_b, m_irq_b);
      check("cyc_irq_a", irq_a, m_irq_a);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge m2);
  endtask

  task automatic pulse(input int lo, input int hi);
    ppu_a12 = 1'b0;
    repeat (lo) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (hi) @(negedge m2);
    ppu_a12 = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [CNT_W-1:0] d);
    bus_if.reg_we   = 1'b1;
    bus_if.reg_sel  = sel;
    bus_if.reg_data = d;
    @(negedge m2);
    bus_if.reg_we   = 1'b0;
  endtask

  initial begin
    bus_if.reg_we   = 1'b0;
    bus_if.reg_sel  = 2'b00;
    bus_if.reg_data = '0;

    // Reset for two posedges while A12 toggles.
    @(negedge m2);
    ppu_a12 = 1'b1;
    @(negedge m2);
    check("reset_counter", cnt_b, 0);
    check("reset_irq_b", irq_b, 0);
    check("reset_irq_a", irq_a, 0);
    reset_n = 1'b1;
    ppu_a12 = 1'b1;
    // A12 high straight out of reset: only two low samples precede it.
    wr(IRQ_LATCH, 8'd7);
    wr(IRQ_ENABLE, 8'd0);
    idle(2);
    pulse(2, 3);
    idle(3);
    check("post_reset_short_low", cnt_b, 0);
    pulse(3, 2);
    idle(3);
    check("post_reset_first_edge", cnt_b, 7);

    // Basic count 3,2,1,0.
    wr(IRQ_LATCH, 8'd3);
    wr(IRQ_RELOAD, 8'd0);
    wr(IRQ_ENABLE, 8'd0);
    for (int i = 0; i < 4; i++) begin
      pulse(4, 2);
      idle(2);
      check("basic_counter", cnt_b, 3 - i);
      check("basic_irq_b", irq_b, (i == 3));
      check("basic_irq_a", irq_a, (i == 3));
    end
    wr(IRQ_DISABLE, 8'd0);
    check("ack_irq_b", irq_b, 0);
    check("ack_irq_a", irq_a, 0);

    // Low-time filter.
    wr(IRQ_LATCH, 8'd9);
    wr(IRQ_RELOAD, 8'd0);
    pulse(4, 2);
    pulse(2, 2);
    pulse(2, 2);
    check("filter_two_low", cnt_b, 9);
    pulse(3, 2);
    idle(3);
    check("filter_three_low", cnt_b, 8);

    // Latch = 0.
    wr(IRQ_LATCH, 8'd0);
    wr(IRQ_RELOAD, 8'd0);
    wr(IRQ_ENABLE, 8'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(4, 2);
      idle(3);
      check("zero_counter", cnt_b, 0);
      check("zero_irq_b", irq_b, 1);
      check("zero_irq_a", irq_a, (i == 0));
      wr(IRQ_DISABLE, 8'd0);
      wr(IRQ_ENABLE, 8'd0);
      check("zero_ack_b", irq_b, 0);
      check("zero_ack_a", irq_a, 0);
    end

    // Collision: $C001 lands on the same posedge as a qualified edge.
    wr(IRQ_LATCH, 8'd5);
    wr(IRQ_RELOAD, 8'd0);
    pulse(4, 2);
    idle(2);
    check("coll_setup", cnt_b, 5);
    wr(IRQ_LATCH, 8'd6);
    ppu_a12 = 1'b0;
    repeat (4) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (2) @(negedge m2);
    wr(IRQ_RELOAD, 8'd0);
    ppu_a12 = 1'b0;
    idle(2);
    check("coll_counter", cnt_b, 0);
    check("coll_irq_b", irq_b, 0);
    pulse(4, 2);
    idle(2);
    check("coll_next_edge", cnt_b, 6);

    // Disabled: counter reaches zero without an IRQ.
    wr(IRQ_DISABLE, 8'd0);
    wr(IRQ_LATCH, 8'd1);
    wr(IRQ_RELOAD, 8'd0);
    pulse(4, 2);
    idle(2);
    check("dis_counter1", cnt_b, 1);
    pulse(4, 2);
    idle(2);
    check("dis_counter0", cnt_b, 0);
    check("dis_irq_b", irq_b, 0);
    check("dis_irq_a", irq_a, 0);
    wr(IRQ_ENABLE, 8'd0);
    idle(3);
    check("reen_irq_b", irq_b, 0);
    check("reen_irq_a", irq_a, 0);

    idle(2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
